// File: rtl/data_mem_responder_if.sv
// Bus between the CPU MEM stage / host loader and data_mem_responder.
// The master drives requests and the slave (the responder) returns read data and status.
interface data_mem_responder_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 10
);
  logic [N-1:0]      address_i;
  logic [N-1:0]      data_i;
  logic              we_i;
  logic [N-1:0]      data_o;
  logic              host_valid_i;
  logic              host_ready_o;
  logic [ADDR_W-1:0] host_addr_i;
  logic [N-1:0]      host_data_i;
  logic [N-1:0]      gpio_o;
  logic              oor_o;

  modport master (
    output address_i, data_i, we_i, host_valid_i, host_addr_i, host_data_i,
    input  data_o, host_ready_o, gpio_o, oor_o
  );

  modport slave (
    input  address_i, data_i, we_i, host_valid_i, host_addr_i, host_data_i,
    output data_o, host_ready_o, gpio_o, oor_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// CPU data-memory responder: word RAM with combinational read, GPIO / cycle counter / host-count MMIO,
// and a host preload port. Define CYCLE_COUNTER_EN to build the cycle counter at IO_BASE+1.
module data_mem_responder #(
  parameter int           N       = 32,
  parameter int           DEPTH   = 1024,
  parameter int           ADDR_W  = 10,
  parameter logic [N-1:0] IO_BASE = 32'h0000_F000
) (
  input logic                CLK,
  input logic                RST,
  data_mem_responder_if.slave bus
);

  logic [N-1:0]  r_mem [0:DEPTH-1];
  logic [N-1:0]  r_gpio;
  logic [15:0]   r_host_cnt;
  logic          r_oor;

  logic          w_ram_hit;
  logic          w_io0_hit;
  logic          w_io2_hit;
  logic          w_io1_hit;
  logic          w_wr_legal;
  logic          w_cpu_ram_wr;
  logic          w_host_xfer;
  logic          w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [N-1:0]  w_mem_wdata;
  logic [N-1:0]  w_rdata;

  assign w_ram_hit = (bus.address_i < N'(DEPTH));
  assign w_io0_hit = (bus.address_i == IO_BASE);
  assign w_io2_hit = (bus.address_i == IO_BASE + N'(2));

`ifdef CYCLE_COUNTER_EN
  logic [N-1:0] r_cycle;
  assign w_io1_hit = (bus.address_i == IO_BASE + N'(1));

  // A CPU write to the counter replaces that cycle's increment.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                          r_cycle <= '0;
    else if (bus.we_i && w_io1_hit)    r_cycle <= bus.data_i;
    else                               r_cycle <= r_cycle + N'(1);
  end
`else
  assign w_io1_hit = 1'b0;
`endif

  assign w_wr_legal = w_ram_hit | w_io0_hit | w_io1_hit;

  // Host handshake: a word moves on a rising edge where host_valid_i && host_ready_o; the host
  // holds addr/data stable until then. Ready drops only while the CPU owns the RAM write port.
  assign w_cpu_ram_wr     = bus.we_i && w_ram_hit;
  assign bus.host_ready_o = !w_cpu_ram_wr;
  assign w_host_xfer      = bus.host_valid_i && bus.host_ready_o;

  assign w_mem_we    = RST && (w_cpu_ram_wr || w_host_xfer);
  assign w_mem_addr  = w_cpu_ram_wr ? bus.address_i[ADDR_W-1:0] : bus.host_addr_i;
  assign w_mem_wdata = w_cpu_ram_wr ? bus.data_i : bus.host_data_i;

  // RAM contents survive reset, so this array has no reset term.
  always_ff @(posedge CLK) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_gpio     <= '0;
      r_host_cnt <= '0;
      r_oor      <= 1'b0;
    end else begin
      if (bus.we_i && w_io0_hit)              r_gpio <= bus.data_i;
      if (bus.we_i && !w_wr_legal)            r_oor  <= 1'b1;
      if (w_host_xfer && r_host_cnt != 16'hFFFF) r_host_cnt <= r_host_cnt + 16'd1;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_ram_hit)      w_rdata = r_mem[bus.address_i[ADDR_W-1:0]];
    else if (w_io0_hit) w_rdata = r_gpio;
`ifdef CYCLE_COUNTER_EN
    else if (w_io1_hit) w_rdata = r_cycle;
`endif
    else if (w_io2_hit) w_rdata = N'(r_host_cnt);
  end

  assign bus.data_o = w_rdata;
  assign bus.gpio_o = r_gpio;
  assign bus.oor_o  = r_oor;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, reset/counter sequences, then random traffic
// checked against a word-level reference model of the memory map.
module tb_data_mem_responder;
  localparam logic [31:0] IO = 32'h0000_F000;
`ifdef CYCLE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  data_mem_responder_if #(.N(32), .ADDR_W(10)) bus();

  data_mem_responder dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  // Reference model of the architectural state.
  logic [31:0] m_mem [0:1023];
  logic [31:0] m_gpio = '0;
  logic [31:0] m_cnt  = '0;
  logic [15:0] m_hcnt = '0;
  logic        m_oor  = 1'b0;

  function automatic logic exp_ready();
    return !(bus.we_i && bus.address_i < 32'd1024);
  endfunction

  function automatic logic [31:0] exp_read(logic [31:0] a);
    if (a < 32'd1024)               return m_mem[a[9:0]];
    if (a == IO)                    return m_gpio;
    if (a == IO + 32'd1 && CNT_EN)  return m_cnt;
    if (a == IO + 32'd2)            return {16'h0, m_hcnt};
    return 32'h0;
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_gpio <= '0; m_cnt <= '0; m_hcnt <= '0; m_oor <= 1'b0;
    end else begin
      if (bus.we_i) begin
        if (bus.address_i < 32'd1024)                  m_mem[bus.address_i[9:0]] <= bus.data_i;
        else if (bus.address_i == IO)                  m_gpio <= bus.data_i;
        else if (CNT_EN && bus.address_i == IO + 32'd1) m_cnt <= bus.data_i;
        else                                           m_oor <= 1'b1;
      end
      if (!(CNT_EN && bus.we_i && bus.address_i == IO + 32'd1)) m_cnt <= m_cnt + 32'd1;
      if (bus.host_valid_i && exp_ready()) begin
        m_mem[bus.host_addr_i] <= bus.host_data_i;
        if (m_hcnt != 16'hFFFF) m_hcnt <= m_hcnt + 16'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic hv, input logic [9:0] ha, input logic [31:0] hd);
    bus.we_i = we; bus.address_i = a; bus.data_i = d;
    bus.host_valid_i = hv; bus.host_addr_i = ha; bus.host_data_i = hd;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        hv;
    logic [9:0]  haddr;
    logic [31:0] hdata;
    logic        chk_d;
    logic [31:0] exp_d;
    logic        exp_rdy;
    logic [31:0] exp_gpio;
    logic        exp_oor;
  } vec_t;

  vec_t vecs[$];
  logic xfer;

  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b0, 10'h0, 32'h0);

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK); bus.address_i = IO + 32'd2; #1;
    chk("rst_gpio", bus.gpio_o, 32'h0);
    chk("rst_oor", {31'h0, bus.oor_o}, 32'h0);
    chk("rst_ready", {31'h0, bus.host_ready_o}, 32'h1);
    chk("rst_hostcnt", bus.data_o, 32'h0);
    @(negedge CLK); RST = 1'b1;

    //                we    addr          data          hv    ha     hdata         chk  exp_d         rdy   gpio      oor
    vecs.push_back('{1'b1, 32'd5,        32'hDEADBEEF, 1'b0, 10'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,    1'b0});
    vecs.push_back('{1'b0, 32'd5,        32'h0,        1'b0, 10'd0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 32'h0,    1'b0});
    vecs.push_back('{1'b1, 32'd6,        32'h11111111, 1'b0, 10'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,    1'b0});
    vecs.push_back('{1'b1, 32'd6,        32'h1,        1'b0, 10'd0, 32'h0,        1'b1, 32'h11111111, 1'b0, 32'h0,    1'b0});
    vecs.push_back('{1'b0, 32'd6,        32'h0,        1'b0, 10'd0, 32'h0,        1'b1, 32'h1,        1'b1, 32'h0,    1'b0});
    vecs.push_back('{1'b1, 32'd3,        32'h33,       1'b1, 10'd7, 32'h77777777, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0});
    vecs.push_back('{1'b0, 32'd7,        32'h0,        1'b1, 10'd7, 32'h77777777, 1'b0, 32'h0,        1'b1, 32'h0,    1'b0});
    vecs.push_back('{1'b0, IO + 32'd2,   32'h0,        1'b0, 10'd0, 32'h0,        1'b1, 32'h1,        1'b1, 32'h0,    1'b0});
    vecs.push_back('{1'b0, 32'd7,        32'h0,        1'b0, 10'd0, 32'h0,        1'b1, 32'h77777777, 1'b1, 32'h0,    1'b0});
    vecs.push_back('{1'b0, 32'd3,        32'h0,        1'b0, 10'd0, 32'h0,        1'b1, 32'h33,       1'b1, 32'h0,    1'b0});
    vecs.push_back('{1'b1, IO,           32'hA5,       1'b1, 10'd9, 32'h99,       1'b1, 32'h0,        1'b1, 32'h0,    1'b0});
    vecs.push_back('{1'b0, IO,           32'h0,        1'b0, 10'd0, 32'h0,        1'b1, 32'hA5,       1'b1, 32'hA5,   1'b0});
    vecs.push_back('{1'b0, 32'd9,        32'h0,        1'b0, 10'd0, 32'h0,        1'b1, 32'h99,       1'b1, 32'hA5,   1'b0});
    vecs.push_back('{1'b1, IO + 32'd2,   32'h5,        1'b0, 10'd0, 32'h0,        1'b1, 32'h2,        1'b1, 32'hA5,   1'b0});
    vecs.push_back('{1'b0, IO + 32'd2,   32'h0,        1'b0, 10'd0, 32'h0,        1'b1, 32'h2,        1'b1, 32'hA5,   1'b1});
    vecs.push_back('{1'b1, 32'h8000,     32'h9,        1'b0, 10'd0, 32'h0,        1'b1, 32'h0,        1'b1, 32'hA5,   1'b1});
    vecs.push_back('{1'b0, 32'h8000,     32'h0,        1'b0, 10'd0, 32'h0,        1'b1, 32'h0,        1'b1, 32'hA5,   1'b1});
    vecs.push_back('{1'b0, 32'h0001_0000, 32'h0,       1'b0, 10'd0, 32'h0,        1'b1, 32'h0,        1'b1, 32'hA5,   1'b1});

    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].hv, vecs[i].haddr, vecs[i].hdata);
      #1;
      if (vecs[i].chk_d) chk($sformatf("vec%0d_data", i), bus.data_o, vecs[i].exp_d);
      chk($sformatf("vec%0d_ready", i), {31'h0, bus.host_ready_o}, {31'h0, vecs[i].exp_rdy});
      chk($sformatf("vec%0d_gpio", i), bus.gpio_o, vecs[i].exp_gpio);
      chk($sformatf("vec%0d_oor", i), {31'h0, bus.oor_o}, {31'h0, vecs[i].exp_oor});
    end

    // Reset in the middle of a pending host write
    @(negedge CLK);
    drive(1'b0, 32'd5, 32'h0, 1'b1, 10'd5, 32'h00000BAD);
    #1; RST = 1'b0; #1;
    chk("midrst_gpio", bus.gpio_o, 32'h0);
    chk("midrst_oor", {31'h0, bus.oor_o}, 32'h0);
    chk("midrst_ready", {31'h0, bus.host_ready_o}, 32'h1);
    repeat (2) @(posedge CLK);
    @(negedge CLK); bus.address_i = IO + 32'd2; #1;
    chk("midrst_hostcnt", bus.data_o, 32'h0);
    @(negedge CLK); bus.host_valid_i = 1'b0; RST = 1'b1; bus.address_i = 32'd5; #1;
    chk("midrst_mem5", bus.data_o, 32'hDEADBEEF);
    @(negedge CLK); bus.address_i = IO + 32'd2; #1;
    chk("midrst_hostcnt_after", bus.data_o, 32'h0);

    // Cycle counter window
`ifdef CYCLE_COUNTER_EN
    @(negedge CLK); drive(1'b1, IO + 32'd1, 32'hFFFFFFFE, 1'b0, 10'd0, 32'h0);
    @(negedge CLK); bus.we_i = 1'b0; #1;
    chk("cnt_written", bus.data_o, 32'hFFFFFFFE);
    @(negedge CLK); #1;
    chk("cnt_max", bus.data_o, 32'hFFFFFFFF);
    @(negedge CLK); #1;
    chk("cnt_wrap", bus.data_o, 32'h0);
    chk("cnt_oor", {31'h0, bus.oor_o}, 32'h0);
`else
    @(negedge CLK); drive(1'b0, IO + 32'd1, 32'h0, 1'b0, 10'd0, 32'h0); #1;
    chk("nocnt_read", bus.data_o, 32'h0);
    chk("nocnt_oor_before", {31'h0, bus.oor_o}, 32'h0);
    bus.we_i = 1'b1; bus.data_i = 32'h123;
    @(negedge CLK); bus.we_i = 1'b0; #1;
    chk("nocnt_read_after", bus.data_o, 32'h0);
    chk("nocnt_oor_after", {31'h0, bus.oor_o}, 32'h1);
`endif

    // Preload words 0..63 through the host port
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      drive(1'b0, IO + 32'd2, 32'h0, 1'b1, 10'(i), $urandom);
      #1;
      chk("preload_ready", {31'h0, bus.host_ready_o}, 32'h1);
    end
    @(negedge CLK); bus.host_valid_i = 1'b0; #1;
    chk("preload_hostcnt", bus.data_o, exp_read(IO + 32'd2));

    // Random mixed traffic against the model
    xfer = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      int sel;
      logic [31:0] a;
      @(negedge CLK);
      sel = $urandom_range(0, 9);
      if (sel < 4)       a = 32'($urandom_range(0, 63));
      else if (sel < 7)  a = IO + 32'($urandom_range(0, 2));
      else if (sel == 7) a = IO + 32'($urandom_range(3, 4));
      else if (sel == 8) a = 32'($urandom_range(1024, 4095));
      else               a = 32'h0001_0000 + 32'($urandom_range(0, 65535));
      bus.we_i = ($urandom_range(0, 2) == 0);
      bus.address_i = a;
      bus.data_i = $urandom;
      if (xfer || !bus.host_valid_i) begin
        bus.host_valid_i = ($urandom_range(0, 1) == 1);
        bus.host_addr_i  = 10'($urandom_range(0, 63));
        bus.host_data_i  = $urandom;
      end
      #1;
      chk("rand_data", bus.data_o, exp_read(a));
      chk("rand_ready", {31'h0, bus.host_ready_o}, {31'h0, exp_ready()});
      chk("rand_gpio", bus.gpio_o, m_gpio);
      chk("rand_oor", {31'h0, bus.oor_o}, {31'h0, m_oor});
      xfer = bus.host_valid_i && bus.host_ready_o;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
